// File: rtl/mem_access_unit.sv
// mem_access_unit: pipeline memory stage driving a req/ack data bus with byte lanes and load extension
module mem_access_unit #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        mem_flush,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      rdata_q;
    logic [1:0]       size_q;
    logic [1:0]       lane_q;
    logic             uns_q;
    logic             access;
    logic             misaligned;
    logic [3:0]       be_next;
    logic [31:0]      wdata_next;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic [31:0]      ext;

    assign access     = mem_read_in | mem_write_in;
    assign misaligned = size_in == 2'b01 ? addr_in[0] : size_in[1] ? |addr_in[1:0] : 1'b0;

    always_comb begin
        be_next    = size_in == 2'b00 ? 4'b0001 << addr_in[1:0] :
                     size_in == 2'b01 ? (addr_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_next = size_in == 2'b00 ? {4{wdata_in[7:0]}} :
                     size_in == 2'b01 ? {2{wdata_in[15:0]}} : wdata_in;
        byte_lane  = rdata_q[{lane_q, 3'b000} +: 8];
        half_lane  = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        ext        = size_q == 2'b00 ? {{24{byte_lane[7] & ~uns_q}}, byte_lane} :
                     size_q == 2'b01 ? {{16{half_lane[15] & ~uns_q}}, half_lane} : rdata_q;
    end

    // Reset gates the combinational outputs so a held EX/MEM access cannot leak through
    assign stall     = !reset && (state == BUSY || (state == IDLE && access && !misaligned));
    assign mem_flush = !reset && (state == BUSY || (state == IDLE && access));
    assign misalign  = !reset && state == IDLE && access && misaligned;
    assign load_data = (!reset && state == DONE && !dmem_we) ? ext : 32'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'b0;
            dmem_be    <= 4'b0;
            dmem_wdata <= 32'b0;
            bus_err    <= 1'b0;
            counter    <= '0;
            rdata_q    <= 32'b0;
            size_q     <= 2'b0;
            lane_q     <= 2'b0;
            uns_q      <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: if (access && !misaligned) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= mem_write_in;
                    dmem_addr  <= {addr_in[31:2], 2'b00};
                    dmem_be    <= be_next;
                    dmem_wdata <= wdata_next;
                    size_q     <= size_in;
                    lane_q     <= addr_in[1:0];
                    uns_q      <= unsigned_in;
                    counter    <= '0;
                    state      <= BUSY;
                end
                BUSY: begin
                    counter <= counter + 1'b1;
                    if (dmem_ack) begin
                        rdata_q  <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end else if (counter == CNT_W'(TIMEOUT - 1)) begin
                        bus_err  <= 1'b1;
                        rdata_q  <= 32'b0;
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed accesses checked each cycle against a transaction-level model
`timescale 1ns/1ps
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_in, mem_write_in, unsigned_in;
    logic [1:0]  size_in;
    logic [31:0] addr_in, wdata_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        stall, mem_flush, misalign, bus_err;
    logic [31:0] load_data;

    int n_chk = 0, n_fail = 0, stall_cnt = 0, req_cnt = 0;
    bit check_en = 0;
    logic        exp_stall, exp_flush, exp_mis, exp_req, exp_we, exp_berr;
    logic [31:0] exp_addr, exp_wdata, exp_load;
    logic [3:0]  exp_be;

    always #5 clk = ~clk;

    mem_access_unit #(.CNT_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .size_in(size_in), .unsigned_in(unsigned_in),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .mem_flush(mem_flush), .load_data(load_data),
        .misalign(misalign), .bus_err(bus_err)
    );

    function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    function automatic void check1(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endfunction

    function automatic int nbytes(logic [1:0] s);
        return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_be(logic [1:0] s, logic [31:0] a);
        logic [3:0] m;
        m = 4'((1 << nbytes(s)) - 1);
        return m << (a % 4);
    endfunction

    function automatic logic [31:0] model_wdata(logic [1:0] s, logic [31:0] wd);
        int n;
        n = nbytes(s);
        return n == 1 ? wd[7:0] * 32'h01010101 : n == 2 ? wd[15:0] * 32'h00010001 : wd;
    endfunction

    function automatic logic [31:0] model_load(logic [1:0] s, logic u, logic [31:0] a, logic [31:0] rd);
        logic [63:0] v, m;
        int n;
        n = nbytes(s);
        v = {32'b0, rd} >> (8 * (a % 4));
        m = (64'd1 << (8 * n)) - 64'd1;
        v = v & m;
        if (!u && v[8*n-1]) v = v | ~m;
        return v[31:0];
    endfunction

    always @(negedge clk) if (check_en) begin
        check1("stall", stall, exp_stall);
        check1("mem_flush", mem_flush, exp_flush);
        check1("misalign", misalign, exp_mis);
        check1("dmem_req", dmem_req, exp_req);
        check1("bus_err", bus_err, exp_berr);
        check32("load_data", load_data, exp_load);
        if (exp_req) begin
            check1("dmem_we", dmem_we, exp_we);
            check32("dmem_addr", dmem_addr, exp_addr);
            check32("dmem_be", {28'b0, dmem_be}, {28'b0, exp_be});
            check32("dmem_wdata", dmem_wdata, exp_wdata);
        end
        if (stall) stall_cnt++;
        if (dmem_req) req_cnt++;
    end

    task automatic set_idle_exp();
        exp_stall = 0; exp_flush = 0; exp_mis = 0; exp_req = 0; exp_berr = 0; exp_load = 0;
    endtask

    // ack_wait: number of BUSY cycles before ack; negative means the bus never answers
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                             input int ack_wait, input logic [31:0] lit_load, input int lit_stall,
                             input string tag);
        logic acc, mis, acked;
        int nb;
        acc   = rd | wr;
        mis   = acc && (a % nbytes(sz)) != 0;
        acked = ack_wait >= 0 && ack_wait < TO;
        nb    = acked ? ack_wait + 1 : TO;
        @(posedge clk); #1;
        stall_cnt = 0; req_cnt = 0;
        mem_read_in = rd; mem_write_in = wr; size_in = sz; unsigned_in = u;
        addr_in = a; wdata_in = wd; dmem_ack = 0; dmem_rdata = 32'h0;
        set_idle_exp();
        exp_stall = acc && !mis; exp_flush = acc; exp_mis = mis;
        exp_we = wr; exp_addr = a & 32'hFFFF_FFFC;
        exp_be = model_be(sz, a); exp_wdata = model_wdata(sz, wd);
        if (acc && !mis) begin
            for (int i = 0; i < nb; i++) begin
                @(posedge clk); #1;
                exp_req = 1; exp_stall = 1; exp_flush = 1;
                dmem_ack = acked && i == ack_wait;
                dmem_rdata = dmem_ack ? rdv : ~rdv;
            end
            @(posedge clk); #1;
            dmem_ack = 0; dmem_rdata = 32'h5A5A_5A5A;
            exp_req = 0; exp_stall = 0; exp_flush = 0; exp_berr = !acked;
            exp_load = (wr || !acked) ? 32'h0 : model_load(sz, u, a, rdv);
            @(negedge clk); #1;
            check32({tag, ".load_lit"}, load_data, lit_load);
        end
        @(posedge clk); #1;
        mem_read_in = 0; mem_write_in = 0;
        dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
        set_idle_exp();
        @(negedge clk); #1;
        check32({tag, ".stall_cycles"}, stall_cnt, lit_stall);
        check32({tag, ".req_cycles"}, req_cnt, (acc && !mis) ? nb : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; mem_read_in = 1; mem_write_in = 0; size_in = 2'b10; unsigned_in = 0;
        addr_in = 32'h100; wdata_in = 32'h0; dmem_ack = 0; dmem_rdata = 32'h0;
        set_idle_exp();
        @(posedge clk); @(negedge clk); #1;
        check1("rst.req", dmem_req, 0);
        check1("rst.we", dmem_we, 0);
        check32("rst.addr", dmem_addr, 0);
        check32("rst.be", {28'b0, dmem_be}, 0);
        check32("rst.wdata", dmem_wdata, 0);
        check1("rst.stall", stall, 0);
        check1("rst.flush", mem_flush, 0);
        check1("rst.mis", misalign, 0);
        check32("rst.load", load_data, 0);
        check1("rst.berr", bus_err, 0);
        @(posedge clk); #1;
        reset = 0; mem_read_in = 0;
        check_en = 1;

        do_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 2, "wload");
        do_access(1, 0, 2'b00, 0, 32'h203, 32'h0, 32'h80FF0000, 0, 32'hFFFFFF80, 2, "sbyte");
        do_access(1, 0, 2'b00, 1, 32'h203, 32'h0, 32'h80FF0000, 1, 32'h00000080, 3, "ubyte");
        do_access(0, 1, 2'b01, 0, 32'h12, 32'h0000ABCD, 32'h0, 3, 32'h0, 5, "hstore");
        do_access(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0, 32'h0, 0, "misw");
        do_access(1, 0, 2'b01, 0, 32'h103, 32'h0, 32'h0, 0, 32'h0, 0, "mish");
        do_access(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h12345678, -1, 32'h0, 5, "timeout");
        do_access(1, 0, 2'b10, 0, 32'h304, 32'h0, 32'hCAFEF00D, 3, 32'hCAFEF00D, 5, "ack_at_to");
        do_access(1, 0, 2'b01, 0, 32'h002, 32'h0, 32'h80011234, 0, 32'hFFFF8001, 2, "shalf");
        do_access(1, 1, 2'b00, 0, 32'h001, 32'h0000005A, 32'h0, 1, 32'h0, 3, "both");

        check_en = 0;
        @(posedge clk); #1;
        dmem_ack = 0; mem_read_in = 1; size_in = 2'b10; addr_in = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check1("mid.req", dmem_req, 1);
        #2 reset = 1;
        #1;
        check1("arst.req", dmem_req, 0);
        check1("arst.stall", stall, 0);
        check1("arst.flush", mem_flush, 0);
        @(posedge clk); #1;
        reset = 0; mem_read_in = 0; dmem_ack = 1; dmem_rdata = 32'h1234_5678;
        @(negedge clk); #1;
        check1("late.req", dmem_req, 0);
        check1("late.stall", stall, 0);
        check32("late.load", load_data, 0);
        @(posedge clk); #1;
        dmem_ack = 0;
        @(negedge clk); #1;
        check1("late.berr", bus_err, 0);
        check32("late.load2", load_data, 0);
        set_idle_exp();
        check_en = 1;
        do_access(1, 0, 2'b00, 1, 32'h041, 32'h0, 32'h0000A500, 0, 32'h000000A5, 2, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
